// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared definitions for the sequential divider: FSM state encoding and
// helpers that build the width-dependent special-case constants
// (all-ones and most-negative) for any operand width up to MAX_W.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MAX_W = 256;

    // All ones in the low w bits.
    function automatic logic [MAX_W-1:0] all_ones(input int w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Two's-complement most-negative value for width w (only the MSB set).
    function automatic logic [MAX_W-1:0] most_neg(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step
// One restoring-division iteration. The partial remainder is shifted left
// with the next dividend bit (MSB of quo_in) brought in, then a trial
// subtract of the divisor decides the quotient bit. The quotient bit is
// shifted into the low end of the dividend/quotient register.
// Ports:
//   rem_in   [N:0]   partial remainder before this step
//   quo_in   [N-1:0] dividend bits still to consume / quotient bits so far
//   divisor  [N-1:0] divisor magnitude
//   rem_out  [N:0]   partial remainder after this step
//   quo_out  [N-1:0] quo_in shifted left with the new quotient bit
module div_step #(
    parameter int N = 64
) (
    input  logic [N:0]   rem_in,
    input  logic [N-1:0] quo_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic [N-1:0] quo_out
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;
    logic         q_bit;

    always_comb begin
        shifted = {rem_in, quo_in[N-1]};
        trial   = shifted - {2'b00, divisor};
        // No borrow out of the top bit means the divisor fit.
        q_bit   = ~trial[N+1];
        rem_out = q_bit ? trial[N:0] : shifted[N:0];
        quo_out = {quo_in[N-2:0], q_bit};
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle signed/unsigned integer divider. Divides operand magnitudes
// with a restoring algorithm, one quotient bit per clock, then fixes the
// result signs. Divide-by-zero and signed overflow bypass the iteration.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a division (sampled only in IDLE)
//   is_signed  1 = two's-complement, 0 = unsigned
//   dividend   numerator, captured on acceptance
//   divisor    denominator, captured on acceptance
//   busy       high in CALC and FIX
//   done       one-cycle pulse in DONE; results valid
//   quotient   result, held until overwritten by the next operation
//   remainder  result, held until overwritten by the next operation
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring iteration per cycle, N cycles
// FIX   | apply result signs and publish quotient/remainder
// DONE  | done pulse, then back to IDLE
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0] ALL_ONES = N'(all_ones(N));
    localparam logic [N-1:0] MOST_NEG = N'(most_neg(N));

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [N:0]    rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dsr;
    logic          neg_q, neg_r;

    logic          sgn_a, sgn_b;
    logic [N-1:0]  mag_a, mag_b;
    logic          div_zero, ovf;
    logic [N:0]    rem_step;
    logic [N-1:0]  quo_step;

    assign sgn_a    = is_signed & dividend[N-1];
    assign sgn_b    = is_signed & divisor[N-1];
    // The most-negative dividend negates to itself, which read as unsigned
    // is exactly its magnitude 2^(N-1).
    assign mag_a    = sgn_a ? -dividend : dividend;
    assign mag_b    = sgn_b ? -divisor  : divisor;
    assign div_zero = (divisor == '0);
    assign ovf      = is_signed & (dividend == MOST_NEG) & (divisor == ALL_ONES);

    div_step #(.N(N)) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (dsr),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (div_zero | ovf) ? FIX : CALC;
            CALC: if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC) | (state == FIX);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    cnt <= CW'(N - 1);
                    dsr <= mag_b;
                    // Special cases preload the final result and clear the
                    // sign flags so FIX passes the values through untouched.
                    if (div_zero) begin
                        quo   <= ALL_ONES;
                        rem   <= {1'b0, dividend};
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (ovf) begin
                        quo   <= dividend;
                        rem   <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        quo   <= mag_a;
                        rem   <= '0;
                        neg_q <= sgn_a ^ sgn_b;
                        neg_r <= sgn_a;
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    quotient  <= neg_q ? -quo : quo;
                    remainder <= neg_r ? -rem[N-1:0] : rem[N-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Self-checking bench: a 64-bit and an 8-bit divider share the clock and
// reset. Table-driven vectors cover the main function and special cases;
// hand-written sequences cover ignored starts, back-to-back starts and
// mid-operation reset. Latency is counted with the accepting edge as 1.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic        sel8;
    logic [63:0] a_in, b_in;

    logic        start64, start8;
    logic        busy64, done64, busy8, done8;
    logic [63:0] q64, r64;
    logic [7:0]  q8, r8;

    logic        done_s, busy_s;
    logic [63:0] q_s, r_s;

    assign start64 = start & ~sel8;
    assign start8  = start & sel8;
    assign done_s  = sel8 ? done8 : done64;
    assign busy_s  = sel8 ? busy8 : busy64;
    assign q_s     = sel8 ? {56'b0, q8} : q64;
    assign r_s     = sel8 ? {56'b0, r8} : r64;

    seq_divider #(.N(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .is_signed(is_signed),
        .dividend(a_in), .divisor(b_in),
        .busy(busy64), .done(done64), .quotient(q64), .remainder(r64)
    );

    seq_divider #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(is_signed),
        .dividend(a_in[7:0]), .divisor(b_in[7:0]),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one start at IDLE and wait (bounded) for done. lat is the
    // number of rising edges from the accepting edge to the one raising done.
    task automatic run_op(input logic w8, input logic sg, input logic [63:0] a,
                          input logic [63:0] b, input string nm, output int lat);
        @(negedge clk);
        sel8 = w8; is_signed = sg; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        @(negedge clk);
        chk({nm, "_busy_after_accept"}, {63'b0, busy_s}, 64'd1);
        while (!done_s && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        w8;
        logic        sg;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int lat;
        int dones;
        string nm;

        vecs[0]  = '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66};
        vecs[1]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[2]  = '{1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
        vecs[3]  = '{1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2};
        vecs[4]  = '{1'b0, 1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2};
        vecs[5]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
                     64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        vecs[6]  = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66};
        vecs[7]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'd2,
                     64'hC000_0000_0000_0000, 64'd0, 66};
        vecs[8]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 64'd0, 2};
        vecs[9]  = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'd0, 64'h8000_0000_0000_0000, 66};
        vecs[10] = '{1'b0, 1'b0, 64'd5, 64'd10, 64'd0, 64'd5, 66};
        vecs[11] = '{1'b1, 1'b1, 64'h80, 64'hFF, 64'h80, 64'h00, 2};
        vecs[12] = '{1'b1, 1'b0, 64'h80, 64'hFF, 64'h00, 64'h80, 10};
        vecs[13] = '{1'b1, 1'b1, 64'h80, 64'h03, 64'hD6, 64'hFE, 10};
        vecs[14] = '{1'b1, 1'b1, 64'h64, 64'hF9, 64'hF2, 64'h02, 10};

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; sel8 = 1'b0;
        a_in = '0; b_in = '0;
        #12;
        chk("rst_busy64", {63'b0, busy64}, 64'd0);
        chk("rst_done64", {63'b0, done64}, 64'd0);
        chk("rst_q64", q64, 64'd0);
        chk("rst_r64", r64, 64'd0);
        chk("rst_busy8", {63'b0, busy8}, 64'd0);
        chk("rst_done8", {63'b0, done8}, 64'd0);
        chk("rst_q8", {56'b0, q8}, 64'd0);
        chk("rst_r8", {56'b0, r8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            nm = $sformatf("vec%0d", i);
            run_op(vecs[i].w8, vecs[i].sg, vecs[i].a, vecs[i].b, nm, lat);
            chk({nm, "_latency"}, 64'(lat), 64'(vecs[i].lat));
            chk({nm, "_quotient"}, q_s, vecs[i].q);
            chk({nm, "_remainder"}, r_s, vecs[i].r);
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_done_pulse"}, {63'b0, done_s}, 64'd0);
        end

        // Starts during CALC and in the done cycle are ignored; a start in the
        // following IDLE cycle is accepted.
        @(negedge clk);
        sel8 = 1'b0; is_signed = 1'b0; a_in = 64'd100; b_in = 64'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        a_in = 64'd50; b_in = 64'd5; is_signed = 1'b1; start = 1'b1;
        @(posedge clk);
        lat++;
        #1 start = 1'b0;
        @(negedge clk);
        while (!done64 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("ign_latency", 64'(lat), 64'd66);
        chk("ign_quotient", q64, 64'd14);
        chk("ign_remainder", r64, 64'd2);
        is_signed = 1'b0; a_in = 64'd1000; b_in = 64'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("done_cycle_start_busy", {63'b0, busy64}, 64'd0);
        chk("done_cycle_start_q_held", q64, 64'd14);
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        @(negedge clk);
        chk("idle_start_busy", {63'b0, busy64}, 64'd1);
        while (!done64 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("b2b_latency", 64'(lat), 64'd66);
        chk("b2b_quotient", q64, 64'd100);
        chk("b2b_remainder", r64, 64'd0);

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        a_in = 64'd100; b_in = 64'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'b0, busy64}, 64'd0);
        chk("mid_rst_done", {63'b0, done64}, 64'd0);
        chk("mid_rst_q", q64, 64'd0);
        chk("mid_rst_r", r64, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (done64) dones++;
        end
        chk("mid_rst_no_done", 64'(dones), 64'd0);
        run_op(1'b0, 1'b0, 64'd50, 64'd5, "post_rst", lat);
        chk("post_rst_latency", 64'(lat), 64'd66);
        chk("post_rst_quotient", q64, 64'd10);
        chk("post_rst_remainder", r64, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
